// File: rtl/seg_hex_counter_mux.sv
// seg_hex_counter_mux
//   Multi-digit hex up/down counter with a prescaled step rate, driving a
//   multiplexed common-anode 7-segment display one digit at a time.
//
// Ports
//   clk       system clock, all state on posedge
//   rst       synchronous active-high reset
//   en        1 = prescaler runs and the counter steps on each tick
//   up        count direction on a tick (1 = up, 0 = down)
//   load      1 = load load_val into the counter (wins over a tick)
//   load_val  value to load, 4*DIGITS bits
//   value     current count
//   wrap      one-cycle pulse after a tick that wraps the count
//   duan      segments {dp,g,f,e,d,c,b,a}, active-low
//   wei       digit enables, active-low one-hot
//
// duan and wei are registered from the next-state count and next digit
// index, so a new count shows on the segments on the same edge that
// updates value.
module seg_hex_counter_mux #(
    parameter int              DIGITS    = 4,
    parameter int              TICK_DIV  = 2**26,
    parameter int              SCAN_DIV  = 2**16,
    parameter logic [4*DIGITS-1:0] RESET_VAL = '0,
    parameter bit              BLANK_LZ  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [7:0]            duan,
    output logic [DIGITS-1:0]     wei
);

    localparam int VW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]     PRE_ONE  = PW'(1);
    localparam logic [SW-1:0]     SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]     SCAN_ONE = SW'(1);
    localparam logic [IW-1:0]     IDX_MAX  = IW'(DIGITS - 1);
    localparam logic [IW-1:0]     IDX_ONE  = IW'(1);
    localparam logic [VW-1:0]     VAL_ONE  = VW'(1);
    localparam logic [DIGITS-1:0] WEI_RST  = ~(DIGITS'(1));

    // Active-low segment pattern for one hex nibble; dp is always off.
    function automatic logic [7:0] seg_code(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            4'hF:    code = 8'h8E;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    // A digit above 0 is a leading zero when it and every higher nibble is 0.
    function automatic logic is_lead_zero(input logic [VW-1:0] v,
                                          input logic [IW-1:0] idx);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            nz = nz | ((IW'(i) >= idx) && (v[4*i +: 4] != 4'h0));
        end
        return (idx != '0) && !nz;
    endfunction

    logic [PW-1:0]     pre_r,   pre_nxt_s;
    logic [SW-1:0]     scan_r,  scan_nxt_s;
    logic [IW-1:0]     idx_r,   idx_nxt_s;
    logic [VW-1:0]     value_r, value_nxt_s;
    logic              wrap_r,  wrap_nxt_s;
    logic [7:0]        duan_r,  duan_nxt_s;
    logic [DIGITS-1:0] wei_r,   wei_nxt_s;
    logic              tick_s;
    logic [3:0]        nib_s;

    // Prescaler, counter and wrap next-state; load beats tick.
    always_comb begin
        tick_s      = en && (pre_r == PRE_MAX);
        value_nxt_s = value_r;
        pre_nxt_s   = pre_r;
        wrap_nxt_s  = 1'b0;
        if (load) begin
            value_nxt_s = load_val;
            pre_nxt_s   = '0;
        end else if (tick_s) begin
            pre_nxt_s = '0;
            if (up) begin
                value_nxt_s = value_r + VAL_ONE;
                wrap_nxt_s  = (value_r == '1);
            end else begin
                value_nxt_s = value_r - VAL_ONE;
                wrap_nxt_s  = (value_r == '0);
            end
        end else if (en) begin
            pre_nxt_s = pre_r + PRE_ONE;
        end else begin
            pre_nxt_s = pre_r;
        end
    end

    // Digit scan: dwell SCAN_DIV cycles per digit, round-robin over digits.
    always_comb begin
        scan_nxt_s = scan_r + SCAN_ONE;
        idx_nxt_s  = idx_r;
        if (scan_r == SCAN_MAX) begin
            scan_nxt_s = '0;
            idx_nxt_s  = (idx_r == IDX_MAX) ? '0 : (idx_r + IDX_ONE);
        end else begin
            idx_nxt_s = idx_r;
        end
    end

    // Segment and digit-enable decode from the next count and next digit.
    always_comb begin
        nib_s     = 4'h0;
        wei_nxt_s = '1;
        for (int i = 0; i < DIGITS; i++) begin
            nib_s        = nib_s | (value_nxt_s[4*i +: 4] & {4{idx_nxt_s == IW'(i)}});
            wei_nxt_s[i] = (idx_nxt_s != IW'(i));
        end
        if (BLANK_LZ && is_lead_zero(value_nxt_s, idx_nxt_s)) begin
            duan_nxt_s = 8'hFF;
        end else begin
            duan_nxt_s = seg_code(nib_s);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r   <= '0;
            scan_r  <= '0;
            idx_r   <= '0;
            value_r <= RESET_VAL;
            wrap_r  <= 1'b0;
            duan_r  <= seg_code(RESET_VAL[3:0]);
            wei_r   <= WEI_RST;
        end else begin
            pre_r   <= pre_nxt_s;
            scan_r  <= scan_nxt_s;
            idx_r   <= idx_nxt_s;
            value_r <= value_nxt_s;
            wrap_r  <= wrap_nxt_s;
            duan_r  <= duan_nxt_s;
            wei_r   <= wei_nxt_s;
        end
    end

    assign value = value_r;
    assign wrap  = wrap_r;
    assign duan  = duan_r;
    assign wei   = wei_r;

endmodule

// File: tb/tb_seg_hex_counter_mux.sv
// Bench for seg_hex_counter_mux with DIGITS=4, TICK_DIV=4, SCAN_DIV=2.
// Two instances share all inputs: dut without leading-zero blanking and
// dut_b with it. A cycle-level model tracks the count as an integer and
// derives the scanned digit from the number of cycles since reset.
module tb_seg_hex_counter_mux;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;
    localparam int MODV     = 65536;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [15:0] load_val;
    logic [15:0] value, value_b;
    logic        wrap, wrap_b;
    logic [7:0]  duan, duan_b;
    logic [3:0]  wei, wei_b;

    int vectors     = 0;
    int miscompares = 0;

    // model state
    int m_val = 0;
    int m_pre = 0;
    int m_t   = 0;
    bit m_wrap = 1'b0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_hex_counter_mux #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                          .RESET_VAL(16'h0000), .BLANK_LZ(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value), .wrap(wrap), .duan(duan), .wei(wei));

    seg_hex_counter_mux #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                          .RESET_VAL(16'h0000), .BLANK_LZ(1'b1)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .value(value_b), .wrap(wrap_b), .duan(duan_b), .wei(wei_b));

    always #5 clk = ~clk;

    function automatic int m_idx();
        return (m_t / SCAN_DIV) % DIGITS;
    endfunction

    function automatic logic [3:0] m_wei();
        logic [3:0] w;
        w = 4'hF;
        w[m_idx()] = 1'b0;
        return w;
    endfunction

    function automatic logic [7:0] m_duan(input bit blank);
        int i;
        i = m_idx();
        if (blank && i > 0 && (m_val >> (4 * i)) == 0) return 8'hFF;
        return seg_tab[(m_val >> (4 * i)) & 15];
    endfunction

    // Advance the model with the current inputs, then clock the DUTs.
    task automatic cyc();
        int nv;
        if (rst) begin
            m_val = 0; m_pre = 0; m_t = 0; m_wrap = 1'b0;
        end else begin
            m_t++;
            m_wrap = 1'b0;
            if (load) begin
                m_val = int'(load_val);
                m_pre = 0;
            end else if (en) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre = 0;
                    nv = up ? m_val + 1 : m_val - 1;
                    m_wrap = (nv < 0) || (nv >= MODV);
                    m_val = (nv + MODV) % MODV;
                end else begin
                    m_pre++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
        cyc(); cyc();
        rst = 1'b0;
        vectors++;
        if (value !== 16'h0000) begin miscompares++; $display("FAIL reset_value got=%h exp=%h", value, 16'h0000); end
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        vectors++;
        if (wei !== 4'hE) begin miscompares++; $display("FAIL reset_wei got=%h exp=E", wei); end
        vectors++;
        if (duan !== 8'hC0 || duan_b !== 8'hC0) begin
            miscompares++; $display("FAIL reset_duan got=%h/%h exp=C0", duan, duan_b);
        end
    endtask

    task automatic test_count_up();
        logic [3:0] wseq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        en = 1'b1; up = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            cyc();
            vectors++;
            if (value !== 16'(c / TICK_DIV)) begin
                miscompares++; $display("FAIL count_up_value c=%0d got=%h exp=%h", c, value, 16'(c / TICK_DIV));
            end
            vectors++;
            if (wei !== wseq[(c / SCAN_DIV) % 4] || wei !== m_wei()) begin
                miscompares++; $display("FAIL count_up_wei c=%0d got=%h exp=%h", c, wei, m_wei());
            end
            vectors++;
            if (duan !== m_duan(1'b0) || wrap !== 1'b0) begin
                miscompares++; $display("FAIL count_up_duan c=%0d got=%h/%b exp=%h/0", c, duan, wrap, m_duan(1'b0));
            end
        end
    endtask

    task automatic test_wrap_up();
        load_val = 16'hFFFF; load = 1'b1; en = 1'b1; up = 1'b1;
        cyc();
        load = 1'b0;
        vectors++;
        if (value !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_up_load got=%h exp=FFFF", value); end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            vectors++;
            if (wrap !== (c == 4) || value !== ((c == 4) ? 16'h0000 : 16'hFFFF)) begin
                miscompares++; $display("FAIL wrap_up c=%0d got=%h/%b exp=%h/%b", c, value, wrap, m_val, m_wrap);
            end
        end
        en = 1'b0;
        cyc();
        vectors++;
        if (wrap !== 1'b0) begin miscompares++; $display("FAIL wrap_up_pulse_len got=%b exp=0", wrap); end
    endtask

    task automatic test_wrap_down_hold();
        en = 1'b1; up = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            vectors++;
            if (wrap !== (c == 4) || value !== ((c == 4) ? 16'hFFFF : 16'h0000)) begin
                miscompares++; $display("FAIL wrap_down c=%0d got=%h/%b exp=%h/%b", c, value, wrap, m_val, m_wrap);
            end
        end
        en = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            up = 1'($urandom_range(0, 1));
            cyc();
            vectors++;
            if (value !== 16'hFFFF || wrap !== 1'b0 || wei !== m_wei() || duan !== 8'h8E) begin
                miscompares++;
                $display("FAIL hold c=%0d got=%h/%b/%h/%h exp=FFFF/0/%h/8E", c, value, wrap, wei, duan, m_wei());
            end
        end
    endtask

    task automatic test_load_priority();
        logic [15:0] lv;
        lv = 16'($urandom_range(16, 16'hFFF0));
        en = 1'b1; up = 1'b1;
        cyc(); cyc(); cyc();
        load_val = lv; load = 1'b1;
        cyc();
        load = 1'b0;
        vectors++;
        if (value !== lv) begin miscompares++; $display("FAIL load_vs_tick got=%h exp=%h", value, lv); end
        for (int c = 1; c <= 4; c++) begin
            cyc();
            vectors++;
            if (value !== ((c == 4) ? lv + 16'h0001 : lv)) begin
                miscompares++; $display("FAIL load_restart c=%0d got=%h exp=%h", c, value, m_val);
            end
        end
        rst = 1'b1; load = 1'b1; load_val = ~lv;
        cyc();
        rst = 1'b0; load = 1'b0; en = 1'b0;
        vectors++;
        if (value !== 16'h0000 || wei !== 4'hE || duan !== 8'hC0) begin
            miscompares++; $display("FAIL rst_vs_load got=%h/%h/%h exp=0000/E/C0", value, wei, duan);
        end
    endtask

    task automatic test_blank();
        logic [7:0] exp_a3 [4] = '{8'hB0, 8'h88, 8'hFF, 8'hFF};
        logic [7:0] exp_00 [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        en = 1'b0;
        load_val = 16'h00A3; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (duan_b !== exp_a3[m_idx()] || duan !== seg_tab[(16'h00A3 >> (4 * m_idx())) & 15]) begin
                miscompares++; $display("FAIL blank_a3 idx=%0d got=%h/%h exp=%h", m_idx(), duan_b, duan, exp_a3[m_idx()]);
            end
            cyc();
        end
        load_val = 16'h0000; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vectors++;
            if (duan_b !== exp_00[m_idx()] || wei_b !== m_wei()) begin
                miscompares++; $display("FAIL blank_00 idx=%0d got=%h/%h exp=%h/%h", m_idx(), duan_b, wei_b, exp_00[m_idx()], m_wei());
            end
            cyc();
        end
    endtask

    task automatic test_walk_digit0();
        en = 1'b0;
        for (int n = 0; n < 16; n++) begin
            load_val = 16'($urandom_range(0, 4095)) << 4 | 16'(n);
            load = 1'b1;
            cyc();
            load = 1'b0;
            for (int g = 0; g < 8 && m_idx() != 0; g++) begin
                vectors++;
                if ($countones(~wei) != 1) begin miscompares++; $display("FAIL walk_onehot got=%h", wei); end
                cyc();
            end
            vectors++;
            if (wei !== 4'hE || duan !== seg_tab[n]) begin
                miscompares++; $display("FAIL walk_code n=%0d got=%h/%h exp=E/%h", n, wei, duan, seg_tab[n]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            load     = ($urandom_range(0, 11) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            load_val = ($urandom_range(0, 3) == 0) ? 16'(($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000)
                                                   : 16'($urandom);
            cyc();
            vectors++;
            if (value !== 16'(m_val) || value_b !== 16'(m_val) || wrap !== m_wrap || wrap_b !== m_wrap) begin
                miscompares++; $display("FAIL rand_value c=%0d got=%h/%b exp=%h/%b", c, value, wrap, m_val, m_wrap);
            end
            vectors++;
            if (wei !== m_wei() || wei_b !== m_wei() || $countones(~wei) != 1) begin
                miscompares++; $display("FAIL rand_wei c=%0d got=%h exp=%h", c, wei, m_wei());
            end
            vectors++;
            if (duan !== m_duan(1'b0) || duan_b !== m_duan(1'b1)) begin
                miscompares++; $display("FAIL rand_duan c=%0d got=%h/%h exp=%h/%h", c, duan, duan_b, m_duan(1'b0), m_duan(1'b1));
            end
        end
        rst = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down_hold();
        test_load_priority();
        test_blank();
        test_walk_digit0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
